// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for the pong game.
// Synchronizes the start button, serves the ball, tallies points from
// ball-exit events, freezes play for a number of frames after each point
// and declares the winner. Every output comes straight from a flop.

module pong_match_ctrl #(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       iniciar,
    input  logic       frame_tick,
    input  logic       exit_l,
    input  logic       exit_r,
    input  logic [7:0] rand_in,
    output logic       run,
    output logic       serve,
    output logic       serve_dir_x,
    output logic       serve_dir_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] state,
    output logic       lcd_update
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [7:0] PAUSE_VAL = 8'(PAUSE_FRAMES);

    // Start-button synchronizer and rising-edge detector
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q,  edge_d;
    logic start_pulse;

    // Match state
    state_t     state_q, state_d;
    logic       first_q, first_d;           // next serve direction is random
    logic       point_dir_q, point_dir_d;   // direction towards the conceding player
    logic [7:0] cnt_q, cnt_d;               // remaining pause frames
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;

    // Registered outputs
    logic run_q, run_d;
    logic serve_q, serve_d;
    logic dir_x_q, dir_x_d;
    logic dir_y_q, dir_y_d;
    logic lcd_q, lcd_d;

    // Only the two low bits of the random value steer the serve
    logic unused_rand;
    assign unused_rand = ^rand_in[7:2];

    assign start_pulse = sync2_q & ~edge_q;

    // Next-state and registered-output logic for the whole match
    always_comb begin
        sync1_d     = iniciar;
        sync2_d     = sync1_q;
        edge_d      = sync2_q;
        state_d     = state_q;
        first_d     = first_q;
        point_dir_d = point_dir_q;
        cnt_d       = cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        winner_d    = winner_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        serve_d     = 1'b0;
        lcd_d       = 1'b0;
        run_d       = 1'b0;

        case (state_q)
            IDLE, GAMEOVER: begin
                if (start_pulse) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    winner_d  = 2'b00;
                    first_d   = 1'b1;
                    state_d   = SERVE;
                    lcd_d     = 1'b1;
                end
            end
            SERVE: begin
                first_d = 1'b0;
                state_d = PLAY;
            end
            PLAY: begin
                if (exit_l && exit_r) begin
                    first_d = 1'b1;
                    cnt_d   = PAUSE_VAL;
                    state_d = POINT;
                end else if (exit_l) begin
                    score_r_d   = score_r_q + 4'd1;
                    point_dir_d = 1'b0;
                    cnt_d       = PAUSE_VAL;
                    state_d     = POINT;
                    lcd_d       = 1'b1;
                end else if (exit_r) begin
                    score_l_d   = score_l_q + 4'd1;
                    point_dir_d = 1'b1;
                    cnt_d       = PAUSE_VAL;
                    state_d     = POINT;
                    lcd_d       = 1'b1;
                end
            end
            POINT: begin
                if (frame_tick) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d = 8'd0;
                        if (score_l_q == WIN_VAL) begin
                            winner_d = 2'b01;
                            state_d  = GAMEOVER;
                            lcd_d    = 1'b1;
                        end else if (score_r_q == WIN_VAL) begin
                            winner_d = 2'b10;
                            state_d  = GAMEOVER;
                            lcd_d    = 1'b1;
                        end else begin
                            state_d = SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Directions are captured on entry to SERVE so they are valid with the serve pulse
        if (state_d == SERVE) begin
            serve_d = 1'b1;
            dir_y_d = rand_in[1];
            dir_x_d = first_d ? rand_in[0] : point_dir_q;
        end

        run_d = (state_d == PLAY);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            edge_q      <= 1'b0;
            state_q     <= IDLE;
            first_q     <= 1'b1;
            point_dir_q <= 1'b0;
            cnt_q       <= 8'd0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            winner_q    <= 2'b00;
            run_q       <= 1'b0;
            serve_q     <= 1'b0;
            dir_x_q     <= 1'b0;
            dir_y_q     <= 1'b0;
            lcd_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            edge_q      <= edge_d;
            state_q     <= state_d;
            first_q     <= first_d;
            point_dir_q <= point_dir_d;
            cnt_q       <= cnt_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            winner_q    <= winner_d;
            run_q       <= run_d;
            serve_q     <= serve_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            lcd_q       <= lcd_d;
        end
    end

    assign run         = run_q;
    assign serve       = serve_q;
    assign serve_dir_x = dir_x_q;
    assign serve_dir_y = dir_y_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign winner      = winner_q;
    assign state       = state_q;
    assign lcd_update  = lcd_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed bench for the pong match sequencer,
// built with WIN_SCORE=3 and PAUSE_FRAMES=4.

module tb_pong_match_ctrl;

    logic       Clock;
    logic       Reset_n;
    logic       iniciar;
    logic       frame_tick;
    logic       exit_l;
    logic       exit_r;
    logic [7:0] rand_in;
    logic       run;
    logic       serve;
    logic       serve_dir_x;
    logic       serve_dir_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;
    logic [2:0] state;
    logic       lcd_update;

    int total;
    int bad;

    pong_match_ctrl #(
        .WIN_SCORE    (3),
        .PAUSE_FRAMES (4)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .iniciar     (iniciar),
        .frame_tick  (frame_tick),
        .exit_l      (exit_l),
        .exit_r      (exit_r),
        .rand_in     (rand_in),
        .run         (run),
        .serve       (serve),
        .serve_dir_x (serve_dir_x),
        .serve_dir_y (serve_dir_y),
        .score_l     (score_l),
        .score_r     (score_r),
        .winner      (winner),
        .state       (state),
        .lcd_update  (lcd_update)
    );

    // 10-unit free-running clock
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Drive one cycle of exit/frame pulses, then return just after the sampling edge
    task automatic applyStimulus(input logic l, input logic r, input logic ft);
        exit_l     = l;
        exit_r     = r;
        frame_tick = ft;
        tick();
        exit_l     = 1'b0;
        exit_r     = 1'b0;
        frame_tick = 1'b0;
    endtask

    // One comparison of an observed output against its expected value
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full pause of four frame ticks
    task automatic pauseFrames();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    // Directed scenario
    initial begin
        total      = 0;
        bad        = 0;
        Reset_n    = 1'b0;
        iniciar    = 1'b0;
        frame_tick = 1'b0;
        exit_l     = 1'b0;
        exit_r     = 1'b0;
        rand_in    = 8'h03;

        $display("[TB] reset");
        tick();
        tick();
        checkOutput("rst_state", 8'(state), 8'd0);
        checkOutput("rst_run", 8'(run), 8'd0);
        checkOutput("rst_serve", 8'(serve), 8'd0);
        checkOutput("rst_scores", {score_l, score_r}, 8'h00);
        checkOutput("rst_winner", 8'(winner), 8'd0);
        checkOutput("rst_dirs", {6'd0, serve_dir_x, serve_dir_y}, 8'd0);
        checkOutput("rst_lcd", 8'(lcd_update), 8'd0);
        Reset_n = 1'b1;
        tick();
        tick();

        $display("[TB] start with rand_in=03");
        iniciar = 1'b1;
        tick();
        checkOutput("start_n1_state", 8'(state), 8'd0);
        tick();
        checkOutput("start_n2_state", 8'(state), 8'd0);
        checkOutput("start_n2_serve", 8'(serve), 8'd0);
        tick();
        checkOutput("start_state", 8'(state), 8'd1);
        checkOutput("start_serve", 8'(serve), 8'd1);
        checkOutput("start_dirx", 8'(serve_dir_x), 8'd1);
        checkOutput("start_diry", 8'(serve_dir_y), 8'd1);
        checkOutput("start_lcd", 8'(lcd_update), 8'd1);
        checkOutput("start_run", 8'(run), 8'd0);
        tick();
        checkOutput("play_state", 8'(state), 8'd2);
        checkOutput("play_run", 8'(run), 8'd1);
        checkOutput("play_serve", 8'(serve), 8'd0);
        checkOutput("play_lcd", 8'(lcd_update), 8'd0);

        $display("[TB] exit_l, right scores");
        rand_in = 8'h01;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("exl_state", 8'(state), 8'd3);
        checkOutput("exl_scores", {score_l, score_r}, 8'h01);
        checkOutput("exl_run", 8'(run), 8'd0);
        checkOutput("exl_lcd", 8'(lcd_update), 8'd1);
        tick();
        checkOutput("exl_lcd_once", 8'(lcd_update), 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("exl_pause3_state", 8'(state), 8'd3);
        checkOutput("exl_pause3_serve", 8'(serve), 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("exl_serve_state", 8'(state), 8'd1);
        checkOutput("exl_serve", 8'(serve), 8'd1);
        checkOutput("exl_dirx", 8'(serve_dir_x), 8'd0);
        checkOutput("exl_diry", 8'(serve_dir_y), 8'd0);
        tick();
        checkOutput("exl_play", 8'(state), 8'd2);
        checkOutput("exl_serve_once", 8'(serve), 8'd0);

        $display("[TB] frame_tick in PLAY");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ft_play_state", 8'(state), 8'd2);

        $display("[TB] simultaneous exits");
        rand_in = 8'h01;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("both_state", 8'(state), 8'd3);
        checkOutput("both_scores", {score_l, score_r}, 8'h01);
        checkOutput("both_lcd", 8'(lcd_update), 8'd0);
        pauseFrames();
        checkOutput("both_serve_state", 8'(state), 8'd1);
        checkOutput("both_dirx", 8'(serve_dir_x), 8'd1);
        checkOutput("both_serve_lcd", 8'(lcd_update), 8'd0);
        tick();
        checkOutput("both_play", 8'(state), 8'd2);

        $display("[TB] iniciar held through PLAY");
        for (int i = 0; i < 1000; i++) tick();
        checkOutput("hold_state", 8'(state), 8'd2);
        checkOutput("hold_run", 8'(run), 8'd1);
        checkOutput("hold_scores", {score_l, score_r}, 8'h01);

        $display("[TB] left player wins");
        rand_in = 8'h00;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("w1_score_l", 8'(score_l), 8'd1);
        pauseFrames();
        checkOutput("w1_dirx", 8'(serve_dir_x), 8'd1);
        checkOutput("w1_serve", 8'(serve), 8'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("w2_score_l", 8'(score_l), 8'd2);
        pauseFrames();
        checkOutput("w2_state", 8'(state), 8'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("w3_score_l", 8'(score_l), 8'd3);
        checkOutput("w3_winner_pending", 8'(winner), 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("point_exit_ignored", {score_l, score_r}, 8'h31);
        checkOutput("point_exit_state", 8'(state), 8'd3);
        pauseFrames();
        checkOutput("go_state", 8'(state), 8'd4);
        checkOutput("go_winner", 8'(winner), 8'd1);
        checkOutput("go_run", 8'(run), 8'd0);
        checkOutput("go_lcd", 8'(lcd_update), 8'd1);
        checkOutput("go_serve", 8'(serve), 8'd0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("go_hold_state", 8'(state), 8'd4);
        checkOutput("go_hold_scores", {score_l, score_r}, 8'h31);
        checkOutput("go_hold_lcd", 8'(lcd_update), 8'd0);

        $display("[TB] restart from GAMEOVER");
        iniciar = 1'b0;
        tick();
        tick();
        tick();
        iniciar = 1'b1;
        rand_in = 8'h02;
        tick();
        tick();
        checkOutput("rs_wait_state", 8'(state), 8'd4);
        tick();
        checkOutput("rs_state", 8'(state), 8'd1);
        checkOutput("rs_scores", {score_l, score_r}, 8'h00);
        checkOutput("rs_winner", 8'(winner), 8'd0);
        checkOutput("rs_lcd", 8'(lcd_update), 8'd1);
        checkOutput("rs_dirx", 8'(serve_dir_x), 8'd0);
        checkOutput("rs_diry", 8'(serve_dir_y), 8'd1);
        iniciar = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        pauseFrames();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mid_state", 8'(state), 8'd3);
        checkOutput("mid_score_l", 8'(score_l), 8'd2);

        $display("[TB] asynchronous reset mid-POINT");
        Reset_n = 1'b0;
        #1;
        checkOutput("ar_state", 8'(state), 8'd0);
        checkOutput("ar_scores", {score_l, score_r}, 8'h00);
        checkOutput("ar_run", 8'(run), 8'd0);
        checkOutput("ar_dirs", {6'd0, serve_dir_x, serve_dir_y}, 8'd0);
        checkOutput("ar_winner", 8'(winner), 8'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("ar_stay_state", 8'(state), 8'd0);
        checkOutput("ar_stay_serve", 8'(serve), 8'd0);
        checkOutput("ar_stay_lcd", 8'(lcd_update), 8'd0);
        rand_in = 8'h03;
        iniciar = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("ar_restart_state", 8'(state), 8'd1);
        checkOutput("ar_restart_serve", 8'(serve), 8'd1);
        checkOutput("ar_restart_dirx", 8'(serve_dir_x), 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
